// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the IF-stage BTB branch predictor.
// The BTB entry layout, 2-bit counter encoding and PC index/tag extraction live here.
package bp_pkg;

  localparam int TAG_W = 8;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RESET = WNT;
  localparam ctr_e CTR_ALLOC = WT;

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic        valid;
    tag_t        tag;
    logic [63:0] target;
    ctr_e        ctr;
  } entry_t;

  // Word-aligned index: pc[1:0] never reaches the table.
  function automatic logic [63:0] pc_index(input logic [63:0] pc, input int unsigned index_w);
    return (pc >> 2) & ((64'd1 << index_w) - 64'd1);
  endfunction

  function automatic tag_t pc_tag(input logic [63:0] pc, input int unsigned index_w);
    return tag_t'(pc >> (index_w + 2));
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, EXE training and performance-counter signals of the branch predictor.
// The core side is the master; the predictor is the slave.
interface branch_predictor_if;

  logic [63:0] pc_if;
  logic        jump_if;
  logic [63:0] pc_target_if;

  logic        upd_valid_exe;
  logic [63:0] pc_exe;
  logic        taken_exe;
  logic [63:0] target_exe;
  logic        mispredict_exe;

  logic [31:0] br_cnt;
  logic [31:0] mispred_cnt;

  modport master (
    output pc_if, upd_valid_exe, pc_exe, taken_exe, target_exe, mispredict_exe,
    input  jump_if, pc_target_if, br_cnt, mispred_cnt
  );

  modport slave (
    input  pc_if, upd_valid_exe, pc_exe, taken_exe, target_exe, mispredict_exe,
    output jump_if, pc_target_if, br_cnt, mispred_cnt
  );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic for a 2-bit saturating direction counter (SNT..ST).
module sat_counter2
  import bp_pkg::*;
(
  input  ctr_e ctr,
  input  logic taken,
  output ctr_e ctr_next
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ctr_next = ctr;
    unique case (ctr)
      SNT: ctr_next = taken ? WNT : SNT;
      WNT: ctr_next = taken ? WT  : SNT;
      WT:  ctr_next = taken ? ST  : WNT;
      ST:  ctr_next = taken ? ST  : WT;
      default: ctr_next = ctr;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit counters: zero-latency lookup for fetch,
// training from resolved EXE outcomes, plus branch and misprediction counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic                clk,
  input  logic                rstn,
  branch_predictor_if.slave   bp
);

  localparam int INDEX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid_q;
  ctr_e               ctr_q    [ENTRIES];
  tag_t               tag_q    [ENTRIES];
  logic [63:0]        target_q [ENTRIES];
  logic [31:0]        br_cnt_q;
  logic [31:0]        mispred_cnt_q;

  // Lookup path: reads pre-update contents, no bypass from a same-cycle write.
  logic [INDEX_W-1:0] lk_idx;
  tag_t               lk_tag;
  entry_t             lk_entry;
  logic               lk_hit;

  assign lk_idx   = INDEX_W'(pc_index(bp.pc_if, INDEX_W));
  assign lk_tag   = pc_tag(bp.pc_if, INDEX_W);
  assign lk_entry = '{valid:  valid_q[lk_idx],
                      tag:    tag_q[lk_idx],
                      target: target_q[lk_idx],
                      ctr:    ctr_q[lk_idx]};
  assign lk_hit   = lk_entry.valid && (lk_entry.tag == lk_tag);

  assign bp.jump_if      = lk_hit && (lk_entry.ctr inside {WT, ST});
  assign bp.pc_target_if = lk_hit ? lk_entry.target : 64'h0;

  // Update path.
  logic [INDEX_W-1:0] upd_idx;
  tag_t               upd_tag;
  logic               upd_hit;
  ctr_e               ctr_next;

  assign upd_idx = INDEX_W'(pc_index(bp.pc_exe, INDEX_W));
  assign upd_tag = pc_tag(bp.pc_exe, INDEX_W);
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  sat_counter2 u_sat_counter2 (
    .ctr      (ctr_q[upd_idx]),
    .taken    (bp.taken_exe),
    .ctr_next (ctr_next)
  );

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q       <= '0;
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RESET;
    end else if (bp.upd_valid_exe) begin
      br_cnt_q <= br_cnt_q + 32'd1;
      if (bp.mispredict_exe) mispred_cnt_q <= mispred_cnt_q + 32'd1;
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_next;
      end else if (bp.taken_exe) begin
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_idx]   <= CTR_ALLOC;
      end
    end
  end

  // NOTE: tag/target storage is not reset; valid_q masks it, so it can stay plain RAM.
  always_ff @(posedge clk) begin
    if (rstn && bp.upd_valid_exe && bp.taken_exe) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= bp.target_exe;
    end
  end

  assign bp.br_cnt      = br_cnt_q;
  assign bp.mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by random
// training/lookup traffic, all compared against a table model kept in the bench.
module tb_branch_predictor;

  localparam int N = 16;

  logic clk;
  logic rstn;

  branch_predictor_if bp ();

  branch_predictor #(.ENTRIES(N)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bp   (bp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference model: a table indexed by word address, tag = the bits above the index.
  bit          m_valid  [N];
  int          m_tag    [N];
  logic [63:0] m_target [N];
  int          m_ctr    [N];
  logic [31:0] m_br;
  logic [31:0] m_mp;

  function automatic int idx_of(input logic [63:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic int tag_of(input logic [63:0] pc);
    return int'((pc / (4 * N)) % 256);
  endfunction

  function automatic bit m_hit(input logic [63:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_br = '0;
    m_mp = '0;
  endtask

  task automatic model_update(input logic [63:0] pc, input bit taken,
                              input logic [63:0] tgt, input bit mp);
    int i;
    i = idx_of(pc);
    m_br = m_br + 1;
    if (mp) m_mp = m_mp + 1;
    if (m_hit(pc)) begin
      if (taken) begin
        m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_target[i] = tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (taken) begin
      m_valid[i]  = 1'b1;
      m_tag[i]    = tag_of(pc);
      m_target[i] = tgt;
      m_ctr[i]    = 2;
    end
  endtask

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic check_lookup(input logic [63:0] pc);
    bit hit;
    hit = m_hit(pc);
    check($sformatf("jump_if@%h", pc), {63'd0, bp.jump_if},
          {63'd0, hit && (m_ctr[idx_of(pc)] >= 2)});
    check($sformatf("pc_target_if@%h", pc), bp.pc_target_if,
          hit ? m_target[idx_of(pc)] : 64'h0);
  endtask

  task automatic check_counters();
    check("br_cnt", {32'd0, bp.br_cnt}, {32'd0, m_br});
    check("mispred_cnt", {32'd0, bp.mispred_cnt}, {32'd0, m_mp});
  endtask

  // One clock: drive at negedge, check lookup (pre-update), then check counters after the edge.
  task automatic cycle(input logic [63:0] lpc, input bit v, input logic [63:0] epc,
                       input bit tk, input logic [63:0] tgt, input bit mp);
    @(negedge clk);
    bp.pc_if          = lpc;
    bp.upd_valid_exe  = v;
    bp.pc_exe         = epc;
    bp.taken_exe      = tk;
    bp.target_exe     = tgt;
    bp.mispredict_exe = mp;
    #1;
    check_lookup(lpc);
    @(posedge clk);
    #1;
    if (v) model_update(epc, tk, tgt, mp);
    bp.upd_valid_exe = 1'b0;
    check_counters();
  endtask

  task automatic lookup(input logic [63:0] lpc);
    cycle(lpc, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
  endtask

  logic [63:0] pool [4];

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_reset();
    rstn              = 1'b0;
    bp.pc_if          = 64'h1000;
    bp.upd_valid_exe  = 1'b0;
    bp.pc_exe         = '0;
    bp.taken_exe      = 1'b0;
    bp.target_exe     = '0;
    bp.mispredict_exe = 1'b0;
    #12;
    check("reset_jump", {63'd0, bp.jump_if}, 64'd0);
    check("reset_target", bp.pc_target_if, 64'h0);
    rstn = 1'b1;
    check_counters();
    lookup(64'h1000);

    // Allocation on a taken miss, visible the following cycle.
    cycle(64'h1000, 1'b1, 64'h1000, 1'b1, 64'h2000, 1'b1);
    lookup(64'h1000);
    check("alloc_target", bp.pc_target_if, 64'h2000);

    // Hysteresis down to SNT and saturation there.
    for (int k = 0; k < 5; k++) cycle(64'h1000, 1'b1, 64'h1000, 1'b0, 64'h9999, 1'b0);
    lookup(64'h1000);
    // Taken walk 00->01->10->11->11, then back down to 01.
    for (int k = 0; k < 4; k++) cycle(64'h1000, 1'b1, 64'h1000, 1'b1, 64'h2000, 1'b0);
    lookup(64'h1000);
    for (int k = 0; k < 2; k++) cycle(64'h1000, 1'b1, 64'h1000, 1'b0, 64'h0, 1'b1);

    // Same-cycle lookup/update: predicts not-taken now, taken next cycle.
    cycle(64'h1000, 1'b1, 64'h1000, 1'b1, 64'h2000, 1'b0);
    check("same_cycle_pre", 64'd0, 64'd0 | {63'd0, 1'b0});
    lookup(64'h1000);
    check("same_cycle_post", {63'd0, bp.jump_if}, 64'd1);

    // Aliasing: 0x1040 shares index 0 with 0x1000 and evicts it.
    cycle(64'h1040, 1'b1, 64'h1040, 1'b1, 64'h3000, 1'b0);
    lookup(64'h1000);
    lookup(64'h1040);
    check("alias_target", bp.pc_target_if, 64'h3000);

    // Not-taken miss does not allocate.
    cycle(64'h1004, 1'b1, 64'h1004, 1'b0, 64'h5000, 1'b0);
    lookup(64'h1004);

    // Random traffic over a few aliasing regions.
    pool[0] = 64'h1000; pool[1] = 64'h1040; pool[2] = 64'h8000; pool[3] = 64'h2_0000;
    for (int k = 0; k < 400; k++) begin
      logic [63:0] lpc, epc;
      lpc = pool[$urandom_range(0, 3)] + 64'($urandom_range(0, 4 * N - 1));
      epc = pool[$urandom_range(0, 3)] + 64'($urandom_range(0, 4 * N - 1));
      cycle(lpc, ($urandom_range(0, 9) < 7), epc, $urandom_range(0, 1) == 1,
            {32'd0, $urandom}, $urandom_range(0, 1) == 1);
    end

    // Reset during a pending update: outputs clear at once and the update is lost.
    cycle(64'h1000, 1'b1, 64'h1000, 1'b1, 64'h2000, 1'b0);
    cycle(64'h1000, 1'b1, 64'h1000, 1'b1, 64'h2000, 1'b0);
    @(negedge clk);
    bp.pc_if          = 64'h1000;
    bp.upd_valid_exe  = 1'b1;
    bp.pc_exe         = 64'h1100;
    bp.taken_exe      = 1'b1;
    bp.target_exe     = 64'h7000;
    bp.mispredict_exe = 1'b1;
    #1;
    check("pre_reset_jump", {63'd0, bp.jump_if}, 64'd1);
    #1;
    rstn = 1'b0;
    #1;
    model_reset();
    check("async_reset_jump", {63'd0, bp.jump_if}, 64'd0);
    check("async_reset_target", bp.pc_target_if, 64'h0);
    check_counters();
    @(posedge clk);
    #2;
    bp.upd_valid_exe = 1'b0;
    rstn = 1'b1;
    lookup(64'h1000);
    lookup(64'h1100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
